// File: rtl/sprite_motion_ctrl.sv
`timescale 1ns/1ps
// Rate-limited isometric sprite stepper: map walkability query, teleport targets,
// deferred pillar lift and off-screen hide, driving an erase/draw sprite drawer.
module sprite_motion_ctrl #(
  parameter int X_W      = 9,
  parameter int Y_W      = 8,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int STEP     = 1,
  parameter int RATE_DIV = 6250000,
  parameter int INIT_X   = 95,
  parameter int INIT_Y   = 221
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic           move,
  input  logic [1:0]     dir,
  output logic           qry_req,
  output logic [X_W-1:0] qry_x,
  output logic [Y_W-1:0] qry_y,
  input  logic           qry_ack,
  input  logic           qry_ok,
  input  logic           qry_tele,
  input  logic [X_W-1:0] qry_tx,
  input  logic [Y_W-1:0] qry_ty,
  input  logic           lift,
  input  logic [Y_W-1:0] lift_dy,
  input  logic           hide,
  output logic           drawBG,
  input  logic           doneBG,
  output logic           drawChar,
  input  logic           doneChar,
  output logic [X_W-1:0] xCoordinate,
  output logic [Y_W-1:0] yCoordinate,
  output logic           busy,
  output logic [15:0]    step_count
);

  // state  | meaning
  // IDLE   | waiting for hide, pending lift or a move tick
  // QUERY  | candidate held on qry_x/qry_y until qry_ack
  // ERASE  | drawBG held until doneBG
  // UPDATE | apply STEP / TELE / LIFT to the position
  // DRAW   | drawChar held until doneChar
  // HIDE   | sprite parked off-screen while hide is high
  typedef enum logic [2:0] {S_IDLE, S_QUERY, S_ERASE, S_UPDATE, S_DRAW, S_HIDE} state_t;
  typedef enum logic [1:0] {A_STEP, A_TELE, A_LIFT} act_t;

  localparam int                CNT_W     = $clog2(RATE_DIV);
  localparam logic [CNT_W-1:0]  L_CNT_MAX = CNT_W'(RATE_DIV - 1);
  localparam logic [X_W:0]      L_STEP_X  = (X_W+1)'(STEP);
  localparam logic [Y_W:0]      L_STEP_Y  = (Y_W+1)'(STEP);
  localparam logic [X_W:0]      L_SCR_W   = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]      L_SCR_H   = (Y_W+1)'(SCREEN_H);
  localparam logic [X_W-1:0]    L_INIT_X  = X_W'(INIT_X);
  localparam logic [Y_W-1:0]    L_INIT_Y  = Y_W'(INIT_Y);
  localparam logic [X_W-1:0]    L_HIDE_X  = X_W'(SCREEN_W);
  localparam logic [Y_W-1:0]    L_HIDE_Y  = Y_W'(SCREEN_H);

  state_t           r_state;
  act_t             r_act;
  logic [CNT_W-1:0] r_tick_cnt;
  logic             r_tick;
  logic [X_W-1:0]   r_x;
  logic [Y_W-1:0]   r_y;
  logic [X_W-1:0]   r_tgt_x;
  logic [Y_W-1:0]   r_tgt_y;
  logic             r_lift_pend;
  logic [Y_W-1:0]   r_lift_dy;
  logic [15:0]      r_steps;
  logic             r_qry_req;
  logic             r_draw_bg;
  logic             r_draw_char;
  logic             r_busy;

  logic [X_W:0]     w_cand_x;
  logic [Y_W:0]     w_cand_y;
  logic             w_x_unf;
  logic             w_y_unf;
  logic             w_cand_ok;
  logic [Y_W-1:0]   w_lift_y;

  // Free-running move tick; fires in the cycle the counter has just wrapped to 0.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_tick_cnt <= '0;
      r_tick     <= 1'b0;
    end else begin
      r_tick <= (r_tick_cnt == L_CNT_MAX);
      if (r_tick_cnt == L_CNT_MAX) r_tick_cnt <= '0;
      else                         r_tick_cnt <= r_tick_cnt + 1'b1;
    end
  end

  always_comb begin
    w_x_unf   = dir[0] && ({1'b0, r_x} < L_STEP_X);
    w_y_unf   = dir[1] && ({1'b0, r_y} < L_STEP_Y);
    w_cand_x  = dir[0] ? ({1'b0, r_x} - L_STEP_X) : ({1'b0, r_x} + L_STEP_X);
    w_cand_y  = dir[1] ? ({1'b0, r_y} - L_STEP_Y) : ({1'b0, r_y} + L_STEP_Y);
    w_cand_ok = !w_x_unf && !w_y_unf &&
                (w_cand_x != '0) && (w_cand_y != '0) &&
                (w_cand_x < L_SCR_W) && (w_cand_y < L_SCR_H);
    w_lift_y  = (r_y < r_lift_dy) ? '0 : (r_y - r_lift_dy);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_act       <= A_STEP;
      r_x         <= L_INIT_X;
      r_y         <= L_INIT_Y;
      r_tgt_x     <= '0;
      r_tgt_y     <= '0;
      r_lift_pend <= 1'b0;
      r_lift_dy   <= '0;
      r_steps     <= '0;
      r_qry_req   <= 1'b0;
      r_draw_bg   <= 1'b0;
      r_draw_char <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      if (lift) begin
        r_lift_pend <= 1'b1;
        r_lift_dy   <= lift_dy;
      end
      case (r_state)
        S_IDLE: begin
          if (hide) begin
            r_state <= S_HIDE;
            r_busy  <= 1'b1;
            r_x     <= L_HIDE_X;
            r_y     <= L_HIDE_Y;
          end else if (r_lift_pend) begin
            r_state   <= S_ERASE;
            r_act     <= A_LIFT;
            r_draw_bg <= 1'b1;
            r_busy    <= 1'b1;
          end else if (move && r_tick && w_cand_ok) begin
            r_state   <= S_QUERY;
            r_tgt_x   <= w_cand_x[X_W-1:0];
            r_tgt_y   <= w_cand_y[Y_W-1:0];
            r_qry_req <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        S_QUERY: begin
          if (qry_ack) begin
            r_qry_req <= 1'b0;
            if (qry_tele) begin
              r_act     <= A_TELE;
              r_tgt_x   <= qry_tx;
              r_tgt_y   <= qry_ty;
              r_state   <= S_ERASE;
              r_draw_bg <= 1'b1;
            end else if (qry_ok) begin
              r_act     <= A_STEP;
              r_state   <= S_ERASE;
              r_draw_bg <= 1'b1;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        S_ERASE: begin
          if (doneBG) begin
            r_draw_bg <= 1'b0;
            r_state   <= S_UPDATE;
          end
        end
        S_UPDATE: begin
          r_state     <= S_DRAW;
          r_draw_char <= 1'b1;
          if (r_act == A_LIFT) begin
            r_y <= w_lift_y;
            // a lift arriving in this very cycle stays pending
            if (!lift) r_lift_pend <= 1'b0;
          end else begin
            r_x <= r_tgt_x;
            r_y <= r_tgt_y;
            if (r_steps != 16'hFFFF) r_steps <= r_steps + 16'd1;
          end
        end
        S_DRAW: begin
          if (doneChar) begin
            r_draw_char <= 1'b0;
            r_state     <= S_IDLE;
            r_busy      <= 1'b0;
          end
        end
        S_HIDE: begin
          r_x <= L_HIDE_X;
          r_y <= L_HIDE_Y;
          if (!hide) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_qry_req   <= 1'b0;
          r_draw_bg   <= 1'b0;
          r_draw_char <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign qry_req     = r_qry_req;
  assign qry_x       = r_tgt_x;
  assign qry_y       = r_tgt_y;
  assign drawBG      = r_draw_bg;
  assign drawChar    = r_draw_char;
  assign xCoordinate = r_x;
  assign yCoordinate = r_y;
  assign busy        = r_busy;
  assign step_count  = r_steps;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
`timescale 1ns/1ps
// Scoreboard bench for sprite_motion_ctrl: stimulus pushes expected query, draw and
// snapshot events; a monitor pops and compares them as the DUT presents them.
module tb_sprite_motion_ctrl;

  localparam int K_QRY  = 0;
  localparam int K_DRAW = 1;
  localparam int K_SNAP = 2;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        move = 1'b0;
  logic [1:0]  dir = 2'b00;
  logic        qry_req;
  logic [8:0]  qry_x;
  logic [7:0]  qry_y;
  logic        qry_ack = 1'b0;
  logic        qry_ok = 1'b0;
  logic        qry_tele = 1'b0;
  logic [8:0]  qry_tx = '0;
  logic [7:0]  qry_ty = '0;
  logic        lift = 1'b0;
  logic [7:0]  lift_dy = '0;
  logic        hide = 1'b0;
  logic        drawBG;
  logic        doneBG = 1'b0;
  logic        drawChar;
  logic        doneChar = 1'b0;
  logic [8:0]  xCoordinate;
  logic [7:0]  yCoordinate;
  logic        busy;
  logic [15:0] step_count;

  // map responder configuration
  logic        q_ok = 1'b1;
  logic        q_tele = 1'b0;
  logic        q_noack = 1'b0;
  logic [8:0]  q_tx = '0;
  logic [7:0]  q_ty = '0;

  logic        snap_s = 1'b0;
  logic        tb_done = 1'b0;
  int          tmo_cnt = 0;
  int          n_vec = 0;
  int          n_err = 0;

  typedef struct {
    int kind;
    int x;
    int y;
    int cnt;
    int busy;
  } exp_t;
  exp_t q_exp[$];
  exp_t hold;
  exp_t cur;
  logic have_hold = 1'b0;
  logic prev_req = 1'b0;
  logic prev_char = 1'b0;

  sprite_motion_ctrl #(.RATE_DIV(4)) dut (
    .clock(clock), .resetn(resetn), .move(move), .dir(dir),
    .qry_req(qry_req), .qry_x(qry_x), .qry_y(qry_y), .qry_ack(qry_ack),
    .qry_ok(qry_ok), .qry_tele(qry_tele), .qry_tx(qry_tx), .qry_ty(qry_ty),
    .lift(lift), .lift_dy(lift_dy), .hide(hide),
    .drawBG(drawBG), .doneBG(doneBG), .drawChar(drawChar), .doneChar(doneChar),
    .xCoordinate(xCoordinate), .yCoordinate(yCoordinate), .busy(busy),
    .step_count(step_count)
  );

  always #5 clock = ~clock;

  function automatic void chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endfunction

  // Monitor: compares whenever the DUT raises a query, finishes a draw, or a snapshot is requested.
  initial begin
    forever begin
      @(posedge clock or negedge resetn);
      #1;
      if (tb_done) begin
        chk("pending_expectations", q_exp.size(), 0);
        chk("wait_timeouts", tmo_cnt, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
      end
      if (qry_req && !prev_req) begin
        if (q_exp.size() == 0 || q_exp[0].kind != K_QRY) begin
          n_vec++; n_err++; have_hold = 1'b0;
          $display("FAIL query_event: got query at (%0d,%0d), expected none", qry_x, qry_y);
        end else begin
          hold = q_exp.pop_front();
          have_hold = 1'b1;
          chk("qry_x", int'(qry_x), hold.x);
          chk("qry_y", int'(qry_y), hold.y);
        end
      end else if (qry_req && have_hold) begin
        chk("qry_x_hold", int'(qry_x), hold.x);
        chk("qry_y_hold", int'(qry_y), hold.y);
      end
      if (!qry_req) have_hold = 1'b0;
      if (!drawChar && prev_char) begin
        if (q_exp.size() == 0 || q_exp[0].kind != K_DRAW) begin
          n_vec++; n_err++;
          $display("FAIL draw_event: got draw at (%0d,%0d), expected none", xCoordinate, yCoordinate);
        end else begin
          cur = q_exp.pop_front();
          chk("draw_x", int'(xCoordinate), cur.x);
          chk("draw_y", int'(yCoordinate), cur.y);
          chk("draw_steps", int'(step_count), cur.cnt);
        end
      end
      if (snap_s) begin
        if (q_exp.size() == 0 || q_exp[0].kind != K_SNAP) begin
          n_vec++; n_err++;
          $display("FAIL snap_order: got snapshot, expected %0d queued events first", q_exp.size());
        end else begin
          cur = q_exp.pop_front();
          chk("snap_x", int'(xCoordinate), cur.x);
          chk("snap_y", int'(yCoordinate), cur.y);
          chk("snap_steps", int'(step_count), cur.cnt);
          chk("snap_busy", int'(busy), cur.busy);
          chk("snap_qry_req", int'(qry_req), 0);
          chk("snap_drawBG", int'(drawBG), 0);
        end
      end
      prev_req  = qry_req;
      prev_char = drawChar;
    end
  end

  // Map and sprite-drawer responders: ack one cycle after qry_req, done two cycles after a draw request.
  initial begin : resp
    int qc, bc, cc;
    qc = 0; bc = 0; cc = 0;
    forever begin
      @(negedge clock);
      if (qry_ack) begin
        qry_ack = 1'b0; qc = 0;
      end else if (qry_req) begin
        qc++;
        if (qc == 2 && !q_noack) begin
          qry_ack = 1'b1; qry_ok = q_ok; qry_tele = q_tele; qry_tx = q_tx; qry_ty = q_ty;
        end
      end else qc = 0;
      if (doneBG) begin
        doneBG = 1'b0; bc = 0;
      end else if (drawBG) begin
        bc++;
        if (bc == 3) doneBG = 1'b1;
      end else bc = 0;
      if (doneChar) begin
        doneChar = 1'b0; cc = 0;
      end else if (drawChar) begin
        cc++;
        if (cc == 3) doneChar = 1'b1;
      end else cc = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic sig(input int sel);
    case (sel)
      0:       return qry_req;
      1:       return drawBG;
      default: return drawChar;
    endcase
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_sig(input int sel, input logic lvl, input int budget);
    bit found;
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      cyc(1);
      if (sig(sel) == lvl) found = 1'b1;
    end
    if (!found) tmo_cnt++;
  endtask

  task automatic wait_fall(input int sel);
    wait_sig(sel, 1'b1, 60);
    wait_sig(sel, 1'b0, 60);
  endtask

  task automatic one_move();
    move = 1'b1;
    wait_sig(0, 1'b1, 40);
    move = 1'b0;
  endtask

  task automatic push(input int kind, input int x, input int y, input int c);
    q_exp.push_back('{kind, x, y, c, 0});
  endtask

  task automatic snap(input int x, input int y, input int c, input int b);
    @(negedge clock);
    q_exp.push_back('{K_SNAP, x, y, c, b});
    snap_s = 1'b1;
    @(negedge clock);
    snap_s = 1'b0;
  endtask

  task automatic pulse_lift(input logic [7:0] dy);
    wait_sig(2, 1'b1, 60);
    lift = 1'b1; lift_dy = dy;
    cyc(1);
    lift = 1'b0;
  endtask

  initial begin
    cyc(2);
    snap(95, 221, 0, 0);
    @(negedge clock); resetn = 1'b1;

    // two auto-repeat steps with move held
    push(K_QRY, 96, 222, 0); push(K_DRAW, 96, 222, 1);
    push(K_QRY, 97, 223, 0); push(K_DRAW, 97, 223, 2);
    move = 1'b1;
    wait_fall(2);
    wait_fall(2);
    move = 1'b0;
    snap(97, 223, 2, 0);

    // map refuses the step
    q_ok = 1'b0;
    push(K_QRY, 98, 224, 0);
    one_move();
    cyc(8);
    snap(97, 223, 2, 0);

    // teleport wins over ok
    q_ok = 1'b1; q_tele = 1'b1; q_tx = 9'd126; q_ty = 8'd68;
    push(K_QRY, 98, 224, 0); push(K_DRAW, 126, 68, 3);
    one_move(); wait_fall(2);
    snap(126, 68, 3, 0);

    // teleport to X=1, then X-1 lands on 0 and is never queried
    q_tx = 9'd1; q_ty = 8'd221;
    push(K_QRY, 127, 69, 0); push(K_DRAW, 1, 221, 4);
    one_move(); wait_fall(2);
    dir = 2'b01; move = 1'b1;
    cyc(10);
    snap(1, 221, 4, 0);
    cyc(6);
    move = 1'b0;
    snap(1, 221, 4, 0);

    // teleport to X=319, then X+1 reaches SCREEN_W
    dir = 2'b00; q_tx = 9'd319; q_ty = 8'd100;
    push(K_QRY, 2, 222, 0); push(K_DRAW, 319, 100, 5);
    one_move(); wait_fall(2);
    move = 1'b1; cyc(12); move = 1'b0;
    snap(319, 100, 5, 0);

    // step to Y=200 with lift 74 during its draw
    dir = 2'b11; q_tx = 9'd50; q_ty = 8'd199;
    push(K_QRY, 318, 99, 0); push(K_DRAW, 50, 199, 6);
    one_move(); wait_fall(2);
    dir = 2'b00; q_tele = 1'b0;
    push(K_QRY, 51, 200, 0); push(K_DRAW, 51, 200, 7); push(K_DRAW, 51, 126, 7);
    one_move(); pulse_lift(8'd74); wait_fall(2); wait_fall(2);
    snap(51, 126, 7, 0);

    // lift 250 from Y=200 saturates at 0; then Y-1 underflows
    q_tele = 1'b1; q_tx = 9'd60; q_ty = 8'd199;
    push(K_QRY, 52, 127, 0); push(K_DRAW, 60, 199, 8);
    one_move(); wait_fall(2);
    q_tele = 1'b0;
    push(K_QRY, 61, 200, 0); push(K_DRAW, 61, 200, 9); push(K_DRAW, 61, 0, 9);
    one_move(); pulse_lift(8'd250); wait_fall(2); wait_fall(2);
    dir = 2'b10; move = 1'b1; cyc(12); move = 1'b0;
    snap(61, 0, 9, 0);

    // hide raised mid-erase: the step finishes, then the sprite parks
    dir = 2'b00;
    push(K_QRY, 62, 1, 0); push(K_DRAW, 62, 1, 10);
    one_move();
    wait_sig(1, 1'b1, 40);
    hide = 1'b1;
    wait_fall(2);
    cyc(3);
    snap(320, 240, 10, 1);
    hide = 1'b0;
    cyc(2);
    snap(320, 240, 10, 0);

    // asynchronous reset while a query is outstanding
    dir = 2'b11; q_noack = 1'b1;
    push(K_QRY, 319, 239, 0);
    one_move();
    cyc(1);
    #2;
    q_exp.push_back('{K_SNAP, 95, 221, 0, 0});
    snap_s = 1'b1;
    resetn = 1'b0;
    #3;
    snap_s = 1'b0;
    cyc(2);
    @(negedge clock); resetn = 1'b1;
    q_noack = 1'b0; dir = 2'b00;
    push(K_QRY, 96, 222, 0); push(K_DRAW, 96, 222, 1);
    one_move(); wait_fall(2);
    snap(96, 222, 1, 0);

    cyc(2);
    tb_done = 1'b1;
  end

endmodule

// File: doc/sprite_motion_ctrl.md
Name: sprite_motion_ctrl

Overview:
- Parametrised successor to the single-sprite mover: rate-limited, one-button isometric stepping of a sprite, with walkability delegated to an external map-lookup port instead of hard-coded path geometry.
- Sits between the keyboard/button decoder, the level map ROM/logic and the sprite drawer FSM.
- Adds a configurable step size and auto-repeat while move is held.
- Adds a query handshake, teleport targets from the map, deferred pillar-lift offsets and a hide mode.

Parameters:
- X_W, 9, width of X coordinate.
- Y_W, 8, width of Y coordinate.
- SCREEN_W, 320, first illegal X value.
- SCREEN_H, 240, first illegal Y value.
- STEP, 1, pixels moved per axis per accepted step.
- RATE_DIV, 6250000, clock cycles per move tick (8 Hz at 50 MHz); minimum 2.
- INIT_X, 95, reset X.
- INIT_Y, 221, reset Y.

Ports:
- clock  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- move  in  1  level; request to step while high
- dir  in  2  bit0: 0 → X+STEP, 1 → X−STEP; bit1: 0 → Y+STEP, 1 → Y−STEP
- qry_req  out  1  walkability query valid
- qry_x  out  X_W  candidate X
- qry_y  out  Y_W  candidate Y
- qry_ack  in  1  one-cycle response strobe
- qry_ok  in  1  candidate walkable (sampled with qry_ack)
- qry_tele  in  1  teleport instead of step (sampled with qry_ack)
- qry_tx  in  X_W  teleport target X
- qry_ty  in  Y_W  teleport target Y
- lift  in  1  one-cycle pulse: raise sprite by lift_dy
- lift_dy  in  Y_W  lift amount, sampled with lift
- hide  in  1  level; park sprite off-screen (game finished)
- drawBG  out  1  erase request to sprite drawer
- doneBG  in  1  drawer finished erase
- drawChar  out  1  draw request to sprite drawer
- doneChar  in  1  drawer finished draw
- xCoordinate  out  X_W  current sprite X
- yCoordinate  out  Y_W  current sprite Y
- busy  out  1  high in every state except IDLE
- step_count  out  16  accepted moves since reset, saturating at 0xFFFF

Behaviour:
- Reset (async, resetn=0): state IDLE; xCoordinate=INIT_X, yCoordinate=INIT_Y; tick counter=0; lift_pend=0; step_count=0; all request outputs 0.
- Tick counter counts 0..RATE_DIV−1 continuously.
  - tick=1 for one cycle when the counter wraps to 0.
  - The counter is not gated by state.
- Candidate position is computed each cycle in X_W+1 / Y_W+1 bits from the current position and dir.
  - Out of bounds if either axis underflows, equals 0, is ≥SCREEN_W (X) or is ≥SCREEN_H (Y).
  - Out-of-bounds candidates never reach the query port.
- FSM states:
  - IDLE: priority order hide > lift_pend > (move & tick).
    - hide → HIDE.
    - lift_pend → ERASE with pending action LIFT.
    - move & tick & candidate in bounds → QUERY.
    - move & tick & candidate out of bounds → stay IDLE.
  - QUERY: qry_req=1; qry_x/qry_y are held stable (latched on entry) until qry_ack.
    - qry_ack & qry_tele → ERASE with action TELE (latch qry_tx/qry_ty).
    - qry_ack & qry_ok → ERASE with action STEP.
    - qry_ack with neither set → IDLE.
    - qry_ack may arrive in the same cycle qry_req first rises; there is no timeout.
  - ERASE: drawBG=1 until doneBG is seen, then → UPDATE. drawBG stays high through the doneBG cycle.
  - UPDATE: one cycle; applies the pending action, then → DRAW.
    - STEP: position ← candidate latched at QUERY; step_count increments.
    - TELE: position ← latched target; step_count increments.
    - LIFT: Y ← Y − lift_dy, saturating at 0; X unchanged; lift_pend cleared.
  - DRAW: drawChar=1 until doneChar is seen, then → IDLE.
  - HIDE: position forced to (SCREEN_W, SCREEN_H) truncated to the port widths; no draw requests; stays in HIDE while hide=1; → IDLE when hide drops.
- Lift handling:
  - A lift pulse in any state sets lift_pend and captures lift_dy.
  - A second pulse before service overwrites lift_dy; only one lift is applied.
  - A lift pulse in the same cycle lift_pend is cleared re-sets it (the new lift is not lost).
- Auto-repeat: holding move produces at most one accepted step per tick. A tick arriving while busy is dropped, not queued.
- dir changes after QUERY entry have no effect on the move in flight.
- doneBG/doneChar arriving while not in ERASE/DRAW are ignored.
- Latency, IDLE tick to position update: 1 (QUERY entry) + query latency + erase duration + 1 cycle.

Test Plan:
- Reset, RATE_DIV=4, move=1, dir=00, qry_ack/qry_ok 1 cycle after qry_req, doneBG/doneChar 2 cycles after request → position (96,222) after the first tick and (97,223) after the second; step_count=2; qry_x=96, qry_y=222 stable while qry_req=1.
- INIT_X=1, dir=01 (X−1 → 0), move=1 → qry_req never asserts; busy stays 0; position stays (1,221).
- Query returns qry_ok=0 → no drawBG; returns to IDLE; position unchanged; step_count unchanged.
- Query returns qry_tele=1, qry_tx=126, qry_ty=68 → ERASE/DRAW sequence runs; position becomes (126,68); step_count increments by 1.
- lift with lift_dy=74 pulsed during DRAW of a step at Y=200 → the step completes, then a second erase/draw runs with Y=126. Repeat with lift_dy=250 from Y=200 → Y=0.
- hide=1 mid-ERASE → the erase completes, then the next IDLE cycle enters HIDE with position (320,240 truncated to 8 bits, i.e. 0xF0). Assert resetn=0 mid-QUERY → immediate return to (95,221) and qry_req=0 without waiting for a clock edge.
